// File: rtl/frame_buf_pkg.sv
// Shared constants and read-side state encoding for the SDRAM ping-pong frame buffer clients.
package frame_buf_pkg;

   localparam int unsigned H_ACTIVE    = 1024;
   localparam int unsigned V_ACTIVE    = 768;
   localparam int unsigned FRAME_WORDS = H_ACTIVE * V_ACTIVE;

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_TOGGLE = 2'd1,
      RD_STREAM = 2'd2,
      RD_DRAIN  = 2'd3
   } rd_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with synchronous flush; head word is always on rd_data.
module sync_fifo_fwft #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_wr, do_rd;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_wr && !do_rd) begin
            count_q <= count_q + 1'b1;
         end else if (!do_wr && do_rd) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/vga_frame_reader.sv
// Display-side frame buffer client: toggles the arbiter at frame start, streams one frame of
// words into a prefetch FIFO and serves them to the VGA timing generator on data-enable.
module vga_frame_reader
   import frame_buf_pkg::*;
#(
   parameter int unsigned FRAME_WORDS   = frame_buf_pkg::FRAME_WORDS,
   parameter int unsigned FIFO_DEPTH    = 16,
   parameter int unsigned RD_LATENCY    = 1,
   parameter int unsigned TOGGLE_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        pix_req,
   output logic [15:0] pix_data,
   output logic        pix_valid,
   output logic        mem_toggle,
   input  logic        mem_rdy_to_rd,
   output logic        mem_rd_req,
   input  logic [15:0] mem_dout,
   output logic        busy,
   output logic        underrun,
   output logic        frame_overlap
);

   localparam int unsigned CW  = $clog2(FRAME_WORDS + 1);
   localparam int unsigned TW  = $clog2(TOGGLE_CYCLES + 1);
   localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

   rd_state_e             state_q, state_d;
   logic [TW-1:0]         tog_q, tog_d;
   logic [CW-1:0]         issued_q, issued_d;
   logic [FCW-1:0]        inflight_q, inflight_d;
   logic [RD_LATENCY-1:0] vld_sr_q;
   logic [FCW-1:0]        fifo_count;
   logic [FCW:0]          occupancy;
   logic [15:0]           fifo_rd_data;
   logic                  fifo_empty, fifo_full;
   logic                  flush, ret, pix_pop;

   assign ret       = vld_sr_q[RD_LATENCY-1];
   // Words already requested count against FIFO space so returns can never overflow it.
   assign occupancy = (FCW+1)'(fifo_count) + (FCW+1)'(inflight_q);

   always_comb begin
      state_d    = state_q;
      tog_d      = tog_q;
      issued_d   = issued_q;
      mem_toggle = 1'b0;
      mem_rd_req = 1'b0;
      flush      = 1'b0;
      unique case (state_q)
         RD_IDLE: begin
            if (frame_start) begin
               state_d  = RD_TOGGLE;
               tog_d    = '0;
               issued_d = '0;
               flush    = 1'b1;
            end
         end
         RD_TOGGLE: begin
            mem_toggle = 1'b1;
            tog_d      = tog_q + 1'b1;
            if (tog_q == TW'(TOGGLE_CYCLES - 1)) state_d = RD_STREAM;
         end
         RD_STREAM: begin
            mem_rd_req = mem_rdy_to_rd && (issued_q < CW'(FRAME_WORDS)) &&
                         (occupancy < (FCW+1)'(FIFO_DEPTH)) && !fifo_full;
            if (mem_rd_req) begin
               issued_d = issued_q + 1'b1;
               if (issued_d == CW'(FRAME_WORDS)) state_d = RD_DRAIN;
            end
         end
         RD_DRAIN: begin
            if (inflight_q == '0) state_d = RD_IDLE;
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      inflight_d = inflight_q;
      if (mem_rd_req && !ret) begin
         inflight_d = inflight_q + 1'b1;
      end else if (!mem_rd_req && ret) begin
         inflight_d = inflight_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RD_IDLE;
         tog_q      <= '0;
         issued_q   <= '0;
         inflight_q <= '0;
         vld_sr_q   <= '0;
      end else begin
         state_q    <= state_d;
         tog_q      <= tog_d;
         issued_q   <= issued_d;
         inflight_q <= inflight_d;
         vld_sr_q   <= (vld_sr_q << 1) | RD_LATENCY'(mem_rd_req);
      end
   end

   sync_fifo_fwft #(
      .WIDTH (16),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .wr_en   (ret),
      .wr_data (mem_dout),
      .rd_en   (pix_pop),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign pix_pop       = pix_req & ~fifo_empty;
   assign pix_valid     = pix_pop;
   assign pix_data      = pix_pop ? fifo_rd_data : 16'h0000;
   assign underrun      = pix_req & fifo_empty;
   assign busy          = (state_q != RD_IDLE);
   assign frame_overlap = frame_start & (state_q != RD_IDLE);

endmodule
